pipe_stall_ctrl: RTL
====================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter BRANCH_PENALTY, default 1, meaning IF flush cycles per taken branch (legal 1..3).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning maximum data-memory wait cycles before error (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-005 The block SHALL have port load_use_hz, input, 1, meaning load-use hazard flag from HazardDetectionUnit.
REQ-006 The block SHALL have port branch_taken, input, 1, meaning beq resolved taken (zero & beq).
REQ-007 The block SHALL have port dmem_req, input, 1, meaning MEM-stage load/store access active.
REQ-008 The block SHALL have port dmem_ready, input, 1, meaning data memory completes access this cycle.
REQ-009 The block SHALL have outputs PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write and MEM_WB_Write, each 1 bit, meaning per-stage register write enables.
REQ-010 The block SHALL have outputs ControlMuxSel, 1, meaning insert bubble into ID/EX; IF_Flush, 1, meaning zero the IF/ID register; and mem_err, 1, meaning sticky memory timeout.
REQ-011 The block SHALL have outputs stall_cycles and flush_cycles, each 16 bits, meaning performance counters (see Configuration).

Function
REQ-012 The FSM SHALL have the states RUN, MEM_WAIT, FLUSH and ERROR; all control outputs are Mealy functions of state and inputs, with zero latency.
REQ-013 Freeze SHALL be defined as dmem_req=1 and dmem_ready=0 in RUN or FLUSH, or dmem_ready=0 in MEM_WAIT; while frozen, all five write enables are 0, ControlMuxSel=0 and IF_Flush=0.
REQ-014 Priority SHALL be: ERROR > freeze > FLUSH sequence > load_use_hz > branch_taken.
REQ-015 In RUN, freeze SHALL cause a transition to MEM_WAIT and load the wait counter with 1.
REQ-016 In RUN with no freeze, load_use_hz=1 SHALL drive PCWrite=0, IF_ID_Write=0, ControlMuxSel=1 and the other enables to 1, with the state staying RUN.
REQ-017 In RUN with no freeze and no load_use_hz, branch_taken=1 SHALL drive IF_Flush=1 with all enables 1; if BRANCH_PENALTY>1, the next state is FLUSH with the flush counter set to BRANCH_PENALTY-1.
REQ-018 When load_use_hz and branch_taken are both 1 in RUN, the load-use stall SHALL win and the branch SHALL be ignored, since it is re-presented after the stall.
REQ-019 In MEM_WAIT, dmem_ready=1 SHALL release the freeze in the same cycle (all enables 1) and return to the state held before the wait (RUN or FLUSH); the flush counter holds during the wait.
REQ-020 In MEM_WAIT, the wait counter SHALL increment each frozen cycle; on reaching MEM_TIMEOUT with dmem_ready=0, the FSM goes to ERROR and sets mem_err=1.
REQ-021 In FLUSH, the block SHALL drive IF_Flush=1 with all enables 1, decrement the flush counter, and go to RUN when it reaches 0; load_use_hz and branch_taken are ignored in FLUSH.
REQ-022 ERROR SHALL drive all enables to 0, IF_Flush=0 and ControlMuxSel=1, and SHALL be left only by reset; mem_err stays 1 until reset.

Reset
REQ-023 While rst=1, the state SHALL be RUN, all counters 0, mem_err=0, all write enables 0, IF_Flush=0 and ControlMuxSel=1.
REQ-024 The first rising clk edge after rst deasserts SHALL see normal RUN behaviour; reset asserted mid-MEM_WAIT or mid-FLUSH SHALL abort immediately with no residual flush.

Configuration
REQ-025 With macro STALL_PERF_CNT_EN defined, stall_cycles SHALL count cycles with PCWrite=0 and flush_cycles SHALL count cycles with IF_Flush=1; both are 16-bit, saturate at 16'hFFFF and clear on reset.
REQ-026 Without STALL_PERF_CNT_EN, stall_cycles and flush_cycles SHALL remain as ports and be tied to 0, with no counter flops.

Verification
REQ-027 The bench SHALL cover: RUN with all inputs 0 -> all enables 1, ControlMuxSel=0, IF_Flush=0 every cycle.
REQ-028 The bench SHALL cover: load_use_hz=1 for 1 cycle with branch_taken=1 -> PCWrite=0, IF_ID_Write=0, ControlMuxSel=1, IF_Flush=0 that cycle only.
REQ-029 The bench SHALL cover: BRANCH_PENALTY=3, branch_taken pulse -> IF_Flush=1 for exactly 3 consecutive cycles, then RUN.
REQ-030 The bench SHALL cover: dmem_req=1 with dmem_ready low for 4 cycles then high -> 4 frozen cycles, enables 1 on the ready cycle, stall_cycles=4 with the macro defined.
REQ-031 The bench SHALL cover: MEM_TIMEOUT=8 with dmem_ready never high -> ERROR after 8 cycles, mem_err=1 persisting, cleared only by rst.
REQ-032 The bench SHALL cover: rst asserted in the second FLUSH cycle -> outputs take reset values asynchronously, with no IF_Flush after release.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/memory status inputs and per-stage write-enable outputs of pipe_stall_ctrl.
// master = pipeline/hazard side, slave = the stall controller.
interface pipe_stall_ctrl_if;
    logic        load_use_hz;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;

    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_Write;
    logic        EX_MEM_Write;
    logic        MEM_WB_Write;
    logic        ControlMuxSel;
    logic        IF_Flush;
    logic        mem_err;
    logic [15:0] stall_cycles;
    logic [15:0] flush_cycles;

    modport master (
        output load_use_hz, branch_taken, dmem_req, dmem_ready,
        input  PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
        input  ControlMuxSel, IF_Flush, mem_err, stall_cycles, flush_cycles
    );

    modport slave (
        input  load_use_hz, branch_taken, dmem_req, dmem_ready,
        output PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
        output ControlMuxSel, IF_Flush, mem_err, stall_cycles, flush_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls, branch flushes, data-memory freeze and timeout.
// Optional performance counters are enabled with macro STALL_PERF_CNT_EN.
module pipe_stall_ctrl #(
    parameter int BRANCH_PENALTY = 1,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_FLUSH,
        ST_ERROR
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(BRANCH_PENALTY - 1);
    localparam logic [8:0] TIMEOUT    = 9'(MEM_TIMEOUT);

    state_t     state, state_nxt;
    logic       ret_flush, ret_flush_nxt;   // MEM_WAIT resumes FLUSH instead of RUN
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [1:0] flush_cnt, flush_cnt_nxt;
    logic [8:0] wait_inc;

    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic mux_sel, if_flush;
    logic mem_stall;

    assign mem_stall = bus.dmem_req & ~bus.dmem_ready;
    assign wait_inc  = {1'b0, wait_cnt} + 9'd1;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        ret_flush_nxt = ret_flush;
        wait_cnt_nxt  = wait_cnt;
        flush_cnt_nxt = flush_cnt;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idex_we       = 1'b1;
        exmem_we      = 1'b1;
        memwb_we      = 1'b1;
        mux_sel       = 1'b0;
        if_flush      = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
                    state_nxt     = ST_MEM_WAIT;
                    wait_cnt_nxt  = 8'd1;
                    ret_flush_nxt = 1'b0;
                end else if (bus.load_use_hz) begin
                    // A branch seen alongside a load-use stall is re-presented next cycle.
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    mux_sel = 1'b1;
                end else if (bus.branch_taken) begin
                    if_flush = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_nxt     = ST_FLUSH;
                        flush_cnt_nxt = FLUSH_INIT;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if (!bus.dmem_ready) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
                    wait_cnt_nxt = wait_inc[7:0];
                    if (wait_inc >= TIMEOUT) begin
                        state_nxt = ST_ERROR;
                    end
                end else begin
                    state_nxt = ret_flush ? ST_FLUSH : ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (mem_stall) begin
                    {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
                    state_nxt     = ST_MEM_WAIT;
                    wait_cnt_nxt  = 8'd1;
                    ret_flush_nxt = 1'b1;
                end else begin
                    if_flush      = 1'b1;
                    flush_cnt_nxt = flush_cnt - 2'd1;
                    if (flush_cnt <= 2'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
            end

            ST_ERROR: begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
                mux_sel = 1'b1;
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // Outputs take their safe values for the whole time reset is held.
        if (rst) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b0;
            mux_sel  = 1'b1;
            if_flush = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_flush <= 1'b0;
            wait_cnt  <= 8'd0;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            ret_flush <= ret_flush_nxt;
            wait_cnt  <= wait_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    assign bus.PCWrite       = pc_we;
    assign bus.IF_ID_Write   = ifid_we;
    assign bus.ID_EX_Write   = idex_we;
    assign bus.EX_MEM_Write  = exmem_we;
    assign bus.MEM_WB_Write  = memwb_we;
    assign bus.ControlMuxSel = mux_sel;
    assign bus.IF_Flush      = if_flush;
    assign bus.mem_err       = (state == ST_ERROR);

`ifdef STALL_PERF_CNT_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            if (!pc_we && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (if_flush && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_q;
    assign bus.flush_cycles = flush_q;
`else
    assign bus.stall_cycles = 16'd0;
    assign bus.flush_cycles = 16'd0;
`endif

endmodule
